// File: rtl/goe_port_buf.sv
// goe_port_buf: per-port store-and-forward output buffer.
//
// Holds each incoming 134-bit FAST packet in a circular data buffer until its
// end-of-packet verdict arrives. Kept packets are committed and queued as a
// length descriptor. Dropped, truncated or overflowing packets are rolled back
// to the last commit point. Committed packets are replayed in order under
// downstream backpressure.
//
// Ports
//   clk, rst            sole clock, synchronous active-high reset
//   in_data_wr/in_data  input word strobe / word ([133:132] 01 head, 11 body, 10 tail)
//   in_valid_wr/in_valid verdict strobe with the tail word / 1 keep, 0 drop
//   out_data_wr/out_data registered output word strobe / word
//   out_data_valid_wr/out_data_valid  high with the output tail word
//   out_ready           downstream may accept a word next cycle
//   buf_free            free words, measured against the working write pointer
//   drop_pulse          one-cycle pulse per discarded packet
//   stat_tx_pkt/stat_drop_pkt  packet counters, only with GOE_PORT_BUF_STAT_EN
//
// Optional feature macro: GOE_PORT_BUF_STAT_EN
//
// Write FSM
//   state   | meaning
//   WR_IDLE | waiting for a head word
//   WR_PKT  | storing a packet behind wr_commit
//   WR_DROP | discarding words up to the tail of a rejected packet
//
// Read FSM
//   state   | meaning
//   RD_IDLE | waiting for a descriptor; pop launches the first-word RAM read
//   RD_LOAD | first word prefetched into rd_word, may leave this cycle
//   RD_SEND | remaining words leave as out_ready allows

module goe_port_buf #(
  parameter string PLATFORM = "xilinx",
  parameter int    ADDR_W   = 8,
  parameter int    DESC_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_data_wr,
  input  logic [133:0]      in_data,
  input  logic              in_valid_wr,
  input  logic              in_valid,
  output logic              out_data_wr,
  output logic [133:0]      out_data,
  output logic              out_data_valid_wr,
  output logic              out_data_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   buf_free,
  output logic              drop_pulse
`ifdef GOE_PORT_BUF_STAT_EN
  ,
  output logic [31:0]       stat_tx_pkt,
  output logic [31:0]       stat_drop_pkt
`endif
);

  localparam logic [ADDR_W:0] DEPTH  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_A  = 1;
  localparam logic [DESC_W:0] DDEPTH = {1'b1, {DESC_W{1'b0}}};
  localparam logic [DESC_W:0] ONE_D  = 1;

  typedef enum logic [1:0] {WR_IDLE, WR_PKT, WR_DROP} wr_state_t;
  typedef enum logic [1:0] {RD_IDLE, RD_LOAD, RD_SEND} rd_state_t;

  wr_state_t wr_st, wr_nxt;
  rd_state_t rd_st, rd_nxt;

  logic [ADDR_W:0] wr_work, wr_work_nxt;
  logic [ADDR_W:0] wr_commit, wr_commit_nxt;
  logic [ADDR_W:0] rd_ptr, rd_ptr_nxt;
  logic [ADDR_W:0] len, len_nxt;
  logic [ADDR_W:0] remain, remain_nxt;

  logic [DESC_W:0] desc_wr, desc_rd;
  logic [ADDR_W:0] desc_mem [0:(1<<DESC_W)-1];
  logic [ADDR_W:0] desc_q;
  logic            desc_empty, desc_full;
  logic            push, pop, drop;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr, mem_raddr;
  logic [133:0]      rd_word;

  logic [1:0] wtype;
  logic       is_head, is_body, is_tail;
  logic       full, commit_full;
  logic       rd_xfer, rd_last;

  assign wtype   = in_data[133:132];
  assign is_head = in_data_wr && (wtype == 2'b01);
  assign is_body = in_data_wr && (wtype == 2'b11);
  assign is_tail = in_data_wr && (wtype == 2'b10);

  assign full        = (wr_work - rd_ptr) == DEPTH;
  assign commit_full = (wr_commit - rd_ptr) == DEPTH;
  assign buf_free    = DEPTH - (wr_work - rd_ptr);

  assign desc_empty = (desc_wr == desc_rd);
  assign desc_full  = (desc_wr - desc_rd) == DDEPTH;
  assign desc_q     = desc_mem[desc_rd[DESC_W-1:0]];

  // ---------------------------------------------------------------- write side
  always_comb begin
    wr_nxt        = wr_st;
    wr_work_nxt   = wr_work;
    wr_commit_nxt = wr_commit;
    len_nxt       = len;
    mem_we        = 1'b0;
    mem_waddr     = wr_work[ADDR_W-1:0];
    push          = 1'b0;
    drop          = 1'b0;
    case (wr_st)
      WR_IDLE: begin
        if (is_head) begin
          if (full) begin
            wr_nxt = WR_DROP;
          end else begin
            mem_we      = 1'b1;
            wr_work_nxt = wr_work + ONE_A;
            len_nxt     = ONE_A;
            wr_nxt      = WR_PKT;
          end
        end
      end
      WR_PKT: begin
        if (is_head) begin
          // Missing tail: abandon the partial packet and restart from the
          // commit point with this word as the new head.
          drop        = 1'b1;
          wr_work_nxt = wr_commit;
          if (commit_full) begin
            wr_nxt = WR_DROP;
          end else begin
            mem_we      = 1'b1;
            mem_waddr   = wr_commit[ADDR_W-1:0];
            wr_work_nxt = wr_commit + ONE_A;
            len_nxt     = ONE_A;
          end
        end else if (is_tail) begin
          if (in_valid_wr && in_valid && !desc_full && !full) begin
            mem_we        = 1'b1;
            wr_work_nxt   = wr_work + ONE_A;
            wr_commit_nxt = wr_work + ONE_A;
            push          = 1'b1;
          end else begin
            // A tail that cannot be stored ends the packet here rather than
            // waiting in WR_DROP for a tail that will never come.
            wr_work_nxt = wr_commit;
            drop        = 1'b1;
          end
          wr_nxt = WR_IDLE;
        end else if (is_body) begin
          if (full) begin
            wr_nxt = WR_DROP;
          end else begin
            mem_we      = 1'b1;
            wr_work_nxt = wr_work + ONE_A;
            len_nxt     = len + ONE_A;
          end
        end
      end
      WR_DROP: begin
        if (is_tail) begin
          wr_work_nxt = wr_commit;
          drop        = 1'b1;
          wr_nxt      = WR_IDLE;
        end
      end
      default: wr_nxt = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) desc_mem[desc_wr[DESC_W-1:0]] <= len + ONE_A;
  end

  // ----------------------------------------------------------------- read side
  assign pop     = (rd_st == RD_IDLE) && !desc_empty;
  assign rd_xfer = (rd_st != RD_IDLE) && out_ready;
  assign rd_last = rd_xfer && (remain == ONE_A);

  assign rd_ptr_nxt = rd_xfer ? rd_ptr + ONE_A : rd_ptr;
  // The RAM always reads the word rd_ptr will point at next cycle, so rd_word
  // is the current word whenever the read FSM is out of RD_IDLE.
  assign mem_raddr  = rd_ptr_nxt[ADDR_W-1:0];

  always_comb begin
    rd_nxt     = rd_st;
    remain_nxt = remain;
    case (rd_st)
      RD_IDLE: begin
        if (pop) begin
          remain_nxt = desc_q;
          rd_nxt     = RD_LOAD;
        end
      end
      RD_LOAD, RD_SEND: begin
        rd_nxt = RD_SEND;
        if (rd_xfer) begin
          remain_nxt = remain - ONE_A;
          if (rd_last) rd_nxt = RD_IDLE;
        end
      end
      default: rd_nxt = RD_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- data RAM
  if (PLATFORM == "xilinx") begin : g_ram_xil
    (* ram_style = "block" *) logic [133:0] mem [0:(1<<ADDR_W)-1];
    always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= in_data;
      rd_word <= mem[mem_raddr];
    end
  end else begin : g_ram_gen
    (* ramstyle = "M20K" *) logic [133:0] mem [0:(1<<ADDR_W)-1];
    always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= in_data;
      rd_word <= mem[mem_raddr];
    end
  end

  // --------------------------------------------------------------- registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_st             <= WR_IDLE;
      rd_st             <= RD_IDLE;
      wr_work           <= '0;
      wr_commit         <= '0;
      rd_ptr            <= '0;
      len               <= '0;
      remain            <= '0;
      desc_wr           <= '0;
      desc_rd           <= '0;
      out_data_wr       <= 1'b0;
      out_data          <= '0;
      out_data_valid_wr <= 1'b0;
      out_data_valid    <= 1'b0;
      drop_pulse        <= 1'b0;
    end else begin
      wr_st             <= wr_nxt;
      rd_st             <= rd_nxt;
      wr_work           <= wr_work_nxt;
      wr_commit         <= wr_commit_nxt;
      rd_ptr            <= rd_ptr_nxt;
      len               <= len_nxt;
      remain            <= remain_nxt;
      if (push) desc_wr <= desc_wr + ONE_D;
      if (pop)  desc_rd <= desc_rd + ONE_D;
      out_data_wr       <= rd_xfer;
      if (rd_xfer) out_data <= rd_word;
      out_data_valid_wr <= rd_last;
      out_data_valid    <= rd_last;
      drop_pulse        <= drop;
    end
  end

`ifdef GOE_PORT_BUF_STAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_tx_pkt   <= '0;
      stat_drop_pkt <= '0;
    end else begin
      if (rd_last) stat_tx_pkt   <= stat_tx_pkt + 32'd1;
      if (drop)    stat_drop_pkt <= stat_drop_pkt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_goe_port_buf.sv
// Directed bench for goe_port_buf: one default-size instance (ADDR_W=8) and
// one small instance (ADDR_W=4) for the overflow case.
module tb_goe_port_buf;

  localparam logic [1:0] HEAD = 2'b01;
  localparam logic [1:0] BODY = 2'b11;
  localparam logic [1:0] TAIL = 2'b10;

  logic clk = 1'b0;
  logic rst;

  logic         a_wr, a_vwr, a_v, a_ready;
  logic [133:0] a_data;
  logic         a_owr, a_ovwr, a_ov, a_drop;
  logic [133:0] a_odata;
  logic [8:0]   a_free;

  logic         b_wr, b_vwr, b_v, b_ready;
  logic [133:0] b_data;
  logic         b_owr, b_ovwr, b_ov, b_drop;
  logic [133:0] b_odata;
  logic [4:0]   b_free;

`ifdef GOE_PORT_BUF_STAT_EN
  logic [31:0] a_stx, a_sdrop, b_stx, b_sdrop;
`endif

  goe_port_buf #(.ADDR_W(8), .DESC_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_data_wr(a_wr), .in_data(a_data), .in_valid_wr(a_vwr), .in_valid(a_v),
    .out_data_wr(a_owr), .out_data(a_odata), .out_data_valid_wr(a_ovwr),
    .out_data_valid(a_ov), .out_ready(a_ready), .buf_free(a_free),
    .drop_pulse(a_drop)
`ifdef GOE_PORT_BUF_STAT_EN
    , .stat_tx_pkt(a_stx), .stat_drop_pkt(a_sdrop)
`endif
  );

  goe_port_buf #(.ADDR_W(4), .DESC_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_data_wr(b_wr), .in_data(b_data), .in_valid_wr(b_vwr), .in_valid(b_v),
    .out_data_wr(b_owr), .out_data(b_odata), .out_data_valid_wr(b_ovwr),
    .out_data_valid(b_ov), .out_ready(b_ready), .buf_free(b_free),
    .drop_pulse(b_drop)
`ifdef GOE_PORT_BUF_STAT_EN
    , .stat_tx_pkt(b_stx), .stat_drop_pkt(b_sdrop)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int a_drops = 0;
  int b_drops = 0;
  int tail_cyc = 0;

  logic [133:0] a_cap[$], a_exp[$], b_cap[$], b_exp[$];
  logic [1:0]   a_capf[$], b_capf[$];
  int           a_capc[$];

  always @(negedge clk) begin
    if (a_owr) begin
      a_cap.push_back(a_odata);
      a_capf.push_back({a_ovwr, a_ov});
      a_capc.push_back(cyc);
    end
    if (b_owr) begin
      b_cap.push_back(b_odata);
      b_capf.push_back({b_ovwr, b_ov});
    end
    if (a_drop) a_drops <= a_drops + 1;
    if (b_drop) b_drops <= b_drops + 1;
  end

  task automatic chk(input string tag, input logic [133:0] got, input logic [133:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  function automatic logic [133:0] mk(input logic [1:0] t, input int k);
    logic [31:0] kk;
    kk = k;
    return {t, kk[3:0], {4{kk ^ 32'h5A5A0000}}};
  endfunction

  task automatic drive(input bit sel4, input logic [1:0] t, input int k,
                       input bit vwr, input bit v);
    if (sel4) begin
      b_wr = 1'b1; b_data = mk(t, k); b_vwr = vwr; b_v = v;
    end else begin
      a_wr = 1'b1; a_data = mk(t, k); a_vwr = vwr; a_v = v;
    end
    if (t == TAIL) tail_cyc = cyc;
    tick();
    a_wr = 1'b0; a_vwr = 1'b0; a_v = 1'b0;
    b_wr = 1'b0; b_vwr = 1'b0; b_v = 1'b0;
  endtask

  task automatic send_pkt(input bit sel4, input int n, input int seed,
                          input bit keep, input bit expect_out);
    logic [1:0] t;
    for (int i = 0; i < n; i++) begin
      t = (i == 0) ? HEAD : ((i == n - 1) ? TAIL : BODY);
      if (expect_out) begin
        if (sel4) b_exp.push_back(mk(t, seed + i));
        else      a_exp.push_back(mk(t, seed + i));
      end
      drive(sel4, t, seed + i, i == n - 1, keep);
    end
  endtask

  task automatic clear_q();
    a_cap.delete(); a_capf.delete(); a_capc.delete(); a_exp.delete();
    b_cap.delete(); b_capf.delete(); b_exp.delete();
  endtask

  task automatic check_out(input bit sel4, input string tag);
    int n;
    if (sel4) begin
      chk({tag, "_count"}, b_cap.size(), b_exp.size());
      n = (b_cap.size() < b_exp.size()) ? b_cap.size() : b_exp.size();
      for (int i = 0; i < n; i++) begin
        chk($sformatf("%s_word%0d", tag, i), b_cap[i], b_exp[i]);
        chk($sformatf("%s_flag%0d", tag, i), b_capf[i],
            (i == b_exp.size() - 1) ? 2'b11 : 2'b00);
      end
    end else begin
      chk({tag, "_count"}, a_cap.size(), a_exp.size());
      n = (a_cap.size() < a_exp.size()) ? a_cap.size() : a_exp.size();
      for (int i = 0; i < n; i++) begin
        chk($sformatf("%s_word%0d", tag, i), a_cap[i], a_exp[i]);
        chk($sformatf("%s_flag%0d", tag, i), a_capf[i],
            (i == a_exp.size() - 1) ? 2'b11 : 2'b00);
      end
    end
  endtask

  initial begin
    int d0, seen, cnt, first;
    rst = 1'b1;
    a_wr = 1'b0; a_data = '0; a_vwr = 1'b0; a_v = 1'b0; a_ready = 1'b1;
    b_wr = 1'b0; b_data = '0; b_vwr = 1'b0; b_v = 1'b0; b_ready = 1'b1;
    idle(2);

    // reset state
    chk("rst_out_wr", a_owr, 0);
    chk("rst_out_data", a_odata, 0);
    chk("rst_out_vwr", a_ovwr, 0);
    chk("rst_out_v", a_ov, 0);
    chk("rst_drop", a_drop, 0);
    chk("rst_free", a_free, 256);
    chk("rst_free4", b_free, 16);
    rst = 1'b0;
    idle(2);

    // 1: 4-word good packet, latency and buffer accounting
    clear_q();
    d0 = a_drops;
    send_pkt(0, 4, 100, 1, 1);
    chk("t1_free_committed", a_free, 252);
    idle(30);
    check_out(0, "t1");
    first = (a_capc.size() > 0) ? a_capc[0] : -1000;
    chk("t1_latency", first - tail_cyc, 3);
    chk("t1_free", a_free, 256);
    chk("t1_drops", a_drops - d0, 0);

    // 2: 6-word packet with drop verdict
    clear_q();
    d0 = a_drops;
    send_pkt(0, 6, 200, 0, 0);
    idle(30);
    chk("t2_count", a_cap.size(), 0);
    chk("t2_drop_cycles", a_drops - d0, 1);
    chk("t2_free", a_free, 256);

    // 3: ADDR_W=4 overflow, then a good 3-word packet
    clear_q();
    d0 = b_drops;
    for (int i = 0; i < 20; i++) begin
      if (i == 16) chk("t3_free_full", b_free, 0);
      drive(1, (i == 0) ? HEAD : ((i == 19) ? TAIL : BODY), 300 + i, i == 19, 1'b1);
    end
    send_pkt(1, 3, 400, 1, 1);
    idle(30);
    check_out(1, "t3");
    chk("t3_drops", b_drops - d0, 1);
    chk("t3_free", b_free, 16);

    // 4: 8-word packet, backpressure for 5 cycles after the 3rd word
    clear_q();
    send_pkt(0, 8, 500, 1, 1);
    seen = 0;
    for (int w = 0; w < 40 && seen < 3; w++) begin
      tick();
      if (a_owr) seen++;
    end
    chk("t4_seen3", seen, 3);
    a_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("t4_stall%0d", i), a_owr, 0);
    end
    a_ready = 1'b1;
    idle(30);
    check_out(0, "t4");
    chk("t4_free", a_free, 256);

    // 5: head, body, body, head, body, tail -> first fragment dropped
    clear_q();
    d0 = a_drops;
    drive(0, HEAD, 600, 0, 0);
    drive(0, BODY, 601, 0, 0);
    drive(0, BODY, 602, 0, 0);
    a_exp.push_back(mk(HEAD, 610));
    drive(0, HEAD, 610, 0, 0);
    a_exp.push_back(mk(BODY, 611));
    drive(0, BODY, 611, 0, 0);
    a_exp.push_back(mk(TAIL, 612));
    drive(0, TAIL, 612, 1, 1);
    idle(30);
    check_out(0, "t5");
    chk("t5_drops", a_drops - d0, 1);
    chk("t5_free", a_free, 256);

    // 6: reset in the middle of a 10-word transmission
    clear_q();
    send_pkt(0, 10, 700, 1, 0);
    seen = 0;
    for (int w = 0; w < 40 && seen < 3; w++) begin
      tick();
      if (a_owr) seen++;
    end
    chk("t6_seen3", seen, 3);
    rst = 1'b1;
    tick();
    chk("t6_rst_out_wr", a_owr, 0);
    chk("t6_rst_vwr", a_ovwr, 0);
    chk("t6_rst_data", a_odata, 0);
    chk("t6_rst_free", a_free, 256);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (a_owr) cnt++;
    end
    chk("t6_quiet", cnt, 0);
    chk("t6_free_idle", a_free, 256);
    clear_q();
    send_pkt(0, 3, 800, 1, 1);
    idle(30);
    check_out(0, "t6_after");
    chk("t6_free_end", a_free, 256);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/goe_port_buf.md
Name: goe_port_buf

Overview:
- Per-port store-and-forward output buffer. One instance sits directly downstream of each goe output port (pktout_*_0 / pktout_*_1) and feeds the port transmit logic.
- Accepts 134-bit FAST packet words and holds each packet until its end-of-packet verdict arrives.
- Commits good packets, rolls back dropped or overflowing ones, and releases committed packets in order under downstream backpressure.

Parameters:
- PLATFORM, "xilinx", selects RAM inference style; no functional effect.
- ADDR_W, 8, data buffer holds 2^ADDR_W words.
- DESC_W, 4, descriptor FIFO holds 2^DESC_W committed packets.

Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- in_data_wr  in  1  input word strobe.
- in_data  in  134  [133:132] 01 head / 11 body / 10 tail; [131:128] invalid-byte count; [127:0] payload.
- in_valid_wr  in  1  verdict strobe, coincident with the tail word.
- in_valid  in  1  verdict: 1 keep, 0 drop.
- out_data_wr  out  1  output word strobe.
- out_data  out  134  output word, bit-identical to the input word.
- out_data_valid_wr  out  1  high with the output tail word.
- out_data_valid  out  1  high with the output tail word (committed packets are always valid).
- out_ready  in  1  downstream may accept a word next cycle.
- buf_free  out  ADDR_W+1  free words, measured against the working write pointer.
- drop_pulse  out  1  one-cycle pulse per discarded packet.

Behaviour:
- One clock domain; all registers update on posedge clk.
- Reset:
  - rst=1 clears every pointer, both FSMs, the descriptor FIFO and the packet-length counter.
  - While reset is applied, all outputs are 0 except buf_free, which is 2^ADDR_W.
  - Reset during reception or transmission discards all buffered data. The output is quiet in the cycle after rst is sampled high.
- Pointers:
  - wr_commit marks the end of the last committed packet.
  - wr_work is the current write position.
  - rd_ptr is the current read position.
  - Pointers are ADDR_W+1 bits with natural wrap-around.
  - full when wr_work - rd_ptr == 2^ADDR_W.
  - buf_free = 2^ADDR_W - (wr_work - rd_ptr).
- Write FSM: WR_IDLE, WR_PKT, WR_DROP.
  - WR_IDLE:
    - A head word (in_data_wr=1, [133:132]=01) is written, the length counter is set to 1, and the FSM goes to WR_PKT.
    - Non-head words are ignored.
    - If the buffer is full at the head, the FSM goes to WR_DROP instead.
  - WR_PKT, each word written, length+1:
    - Word arrives while full: go to WR_DROP and discard the word.
    - Tail word with in_valid_wr=1, in_valid=1 and descriptor FIFO not full: write the word; wr_commit <= wr_work+1; push descriptor {length}; go to WR_IDLE.
    - Tail word with in_valid=0, or descriptor FIFO full: wr_work <= wr_commit; drop_pulse=1; go to WR_IDLE.
    - Head word with no preceding tail: roll back the partial packet, drop_pulse=1, then treat the word as a new head (stay in WR_PKT, length=1).
  - WR_DROP:
    - Discard words until the tail.
    - At the tail: wr_work <= wr_commit, drop_pulse=1, go to WR_IDLE.
- Read FSM: RD_IDLE, RD_LOAD, RD_SEND.
  - RD_IDLE: when the descriptor FIFO is non-empty, pop one descriptor, load the remaining count, go to RD_LOAD.
  - RD_LOAD: one-cycle RAM read pre-fetch.
  - RD_SEND:
    - If out_ready=1 in cycle N, one word is presented with out_data_wr=1 in cycle N+1, and rd_ptr advances.
    - If out_ready=0 in cycle N, out_data_wr=0 in cycle N+1 and the word pointer is held.
    - The last word carries out_data_valid_wr=1 and out_data_valid=1.
    - After the last word, return to RD_IDLE.
  - Latency: with out_ready held high, the first word appears 3 cycles after the commit cycle.
  - Packets leave back-to-back with a gap of at most 2 idle cycles.
- Simultaneous events:
  - Commit and pop in the same cycle are both honoured.
  - A word write and a word read in the same cycle are both honoured.
  - buf_free reflects both.
- Outputs are registered. out_data is held at its last value when out_data_wr=0.

Optional Feature:
- Macro GOE_PORT_BUF_STAT_EN.
- Defined:
  - Adds output stat_tx_pkt[31:0], which increments on each output tail word.
  - Adds output stat_drop_pkt[31:0], which increments on each drop_pulse.
  - Both counters wrap at 2^32 and are cleared by rst.
- Undefined: neither port nor its counter exists; all other behaviour is identical.

Test Plan:
- 4-word packet (01,11,11,10), in_valid=1, out_ready=1 -> 4 identical words out; first word 3 cycles after the tail; tail word has out_data_valid_wr=1 and out_data_valid=1; buf_free returns to 256.
- 6-word packet with in_valid=0 -> no out_data_wr; drop_pulse high exactly 1 cycle; buf_free returns to 256.
- ADDR_W=4: 20-word packet, then a 3-word valid packet -> first packet dropped (drop_pulse=1); only the 3-word packet emerges; buf_free=16 afterwards.
- 8-word packet, out_ready=0 for 5 cycles after the 3rd word -> no out_data_wr in the 5 following cycles; all 8 words emerge in order, none duplicated or lost.
- Head, 2 body, head, body, tail (valid=1) -> one drop_pulse; only the 3-word second packet is output.
- Assert rst for 1 cycle during a 10-word transmission -> out_data_wr=0 from the next cycle; buf_free=256; no further output until a new packet is committed.
